// File: rtl/temp_bcd_display_if.sv
// Sample handshake and display bus for temp_bcd_display.
// The master drives samples in; the slave (the decoder) returns the display state.
interface temp_bcd_display_if #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
);
  logic                  start_valid;
  logic                  start_ready;
  logic [IN_WIDTH-1:0]   temp;
  logic [7*DIGITS-1:0]   seg;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negative;
  logic                  over_range;
  logic                  busy;
  logic                  done;

  modport master (
    output start_valid, temp,
    input  start_ready, seg, bcd, negative, over_range, busy, done
  );

  modport slave (
    input  start_valid, temp,
    output start_ready, seg, bcd, negative, over_range, busy, done
  );
endinterface

// File: rtl/temp_bcd_display.sv
// Sequential binary-to-BCD (double dabble) temperature decoder driving DIGITS
// active-low seven-segment digits with sign, leading-zero blanking and over-range dashes.
module temp_bcd_display #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3,
  parameter int SIGNED   = 0,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst,
  temp_bcd_display_if.slave  bus
);

  localparam int NS = (IN_WIDTH + 4) / 3;          // scratch nibbles, never overflows
  localparam int SW = 4 * NS;
  localparam int ND = (NS > DIGITS) ? NS : DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [IN_WIDTH-1:0]   mag_r;
  logic [IN_WIDTH-1:0]   mag_s;
  logic                  sign_r;
  logic                  sign_s;
  logic [SW-1:0]         scratch_r;
  logic [SW-1:0]         scratch_nx_s;
  logic [4*ND-1:0]       pad_s;
  logic [CW-1:0]         cnt_r;
  logic                  last_s;
  logic                  accept_s;
  logic                  ovr_s;
  int                    av_s;
  int                    msd_s;
  int                    pos_s;
  logic [7*DIGITS-1:0]   seg_nx_s;
  logic [4*DIGITS-1:0]   bcd_nx_s;
  logic [7*DIGITS-1:0]   seg_r;
  logic [4*DIGITS-1:0]   bcd_r;
  logic                  negative_r;
  logic                  over_range_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  ready_r;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    add3 = s;
    for (int k = 0; k < NS; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        add3[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end else begin
        add3[4*k +: 4] = s[4*k +: 4];
      end
    end
  endfunction

  assign accept_s = bus.start_valid && ready_r;
  assign last_s   = (cnt_r == CW'(1));

  // Sign and magnitude of the offered sample; the most-negative value wraps to 2^(IN_WIDTH-1).
  always_comb begin
    sign_s = 1'b0;
    mag_s  = bus.temp;
    if ((SIGNED != 0) && bus.temp[IN_WIDTH-1]) begin
      sign_s = 1'b1;
      mag_s  = ~bus.temp + {{(IN_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      sign_s = 1'b0;
      mag_s  = bus.temp;
    end
  end

  // One double-dabble step: add-3 correction, then shift the next magnitude bit in.
  always_comb begin
    scratch_nx_s = '0;
    scratch_nx_s = {add3(scratch_r), mag_r[IN_WIDTH-1]} ;
    pad_s        = '0;
    pad_s[SW-1:0] = scratch_nx_s;
  end

  // Display decode of the final BCD value, used on the last conversion edge.
  always_comb begin
    av_s     = sign_r ? (DIGITS - 1) : DIGITS;
    ovr_s    = 1'b0;
    msd_s    = 0;
    seg_nx_s = '1;
    bcd_nx_s = '0;
    for (int k = 0; k < ND; k++) begin
      if ((k >= av_s) && (pad_s[4*k +: 4] != 4'd0)) begin
        ovr_s = 1'b1;
      end else begin
        ovr_s = ovr_s;
      end
      if ((k < DIGITS) && (pad_s[4*k +: 4] != 4'd0)) begin
        msd_s = k;
      end else begin
        msd_s = msd_s;
      end
    end
    pos_s = (BLANK_LZ != 0) ? (msd_s + 1) : (DIGITS - 1);
    for (int k = 0; k < DIGITS; k++) begin
      if (ovr_s) begin
        seg_nx_s[7*k +: 7] = 7'b0111111;
      end else if (sign_r && (k == pos_s)) begin
        seg_nx_s[7*k +: 7] = 7'b0111111;
      end else if ((BLANK_LZ != 0) && (k > msd_s)) begin
        seg_nx_s[7*k +: 7] = 7'b1111111;
      end else begin
        seg_nx_s[7*k +: 7] = seg7(pad_s[4*k +: 4]);
      end
    end
    if (ovr_s) begin
      bcd_nx_s = '0;
    end else begin
      bcd_nx_s = pad_s[4*DIGITS-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = CONVERT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONVERT: begin
        if (last_s) begin
          state_nx_s = UPDATE;
        end else begin
          state_nx_s = CONVERT;
        end
      end
      UPDATE:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and registered outputs; outputs load on the edge that enters UPDATE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_r        <= '0;
      sign_r       <= 1'b0;
      scratch_r    <= '0;
      cnt_r        <= '0;
      seg_r        <= '1;
      bcd_r        <= '0;
      negative_r   <= 1'b0;
      over_range_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mag_r     <= mag_s;
            sign_r    <= sign_s;
            scratch_r <= '0;
            cnt_r     <= CW'(IN_WIDTH);
          end
        end
        CONVERT: begin
          scratch_r <= scratch_nx_s;
          mag_r     <= mag_r << 1;
          cnt_r     <= cnt_r - CW'(1);
          if (last_s) begin
            seg_r        <= seg_nx_s;
            bcd_r        <= bcd_nx_s;
            negative_r   <= sign_r;
            over_range_r <= ovr_s;
            done_r       <= 1'b1;
          end
        end
        UPDATE:  done_r <= 1'b0;
        default: done_r <= 1'b0;
      endcase
      busy_r  <= (state_nx_s != IDLE);
      ready_r <= (state_nx_s == IDLE);
    end
  end

  assign bus.start_ready = ready_r;
  assign bus.seg         = seg_r;
  assign bus.bcd         = bcd_r;
  assign bus.negative    = negative_r;
  assign bus.over_range  = over_range_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_temp_bcd_display.sv
// Directed bench: four decoder configurations share one sample stream and are
// compared against hand-computed digit patterns.
module tb_temp_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SM = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sv  = 1'b0;
  logic [7:0] tv  = 8'd0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         got;

  always #5 clk = ~clk;

  temp_bcd_display_if #(.IN_WIDTH(8), .DIGITS(3)) ia ();
  temp_bcd_display_if #(.IN_WIDTH(8), .DIGITS(3)) ib ();
  temp_bcd_display_if #(.IN_WIDTH(8), .DIGITS(2)) ic ();
  temp_bcd_display_if #(.IN_WIDTH(8), .DIGITS(3)) id ();

  assign ia.start_valid = sv;  assign ia.temp = tv;
  assign ib.start_valid = sv;  assign ib.temp = tv;
  assign ic.start_valid = sv;  assign ic.temp = tv;
  assign id.start_valid = sv;  assign id.temp = tv;

  temp_bcd_display #(.IN_WIDTH(8), .DIGITS(3), .SIGNED(0), .BLANK_LZ(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
  temp_bcd_display #(.IN_WIDTH(8), .DIGITS(3), .SIGNED(0), .BLANK_LZ(0)) u_b (.clk(clk), .rst(rst), .bus(ib));
  temp_bcd_display #(.IN_WIDTH(8), .DIGITS(2), .SIGNED(0), .BLANK_LZ(1)) u_c (.clk(clk), .rst(rst), .bus(ic));
  temp_bcd_display #(.IN_WIDTH(8), .DIGITS(3), .SIGNED(1), .BLANK_LZ(1)) u_d (.clk(clk), .rst(rst), .bus(id));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for done on the reference instance; got = cycle index after the accept edge, 0 on timeout.
  task automatic wait_done();
    got = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) check_eq("ready_low", {31'd0, ia.start_ready}, 32'd0);
      if (ia.done) begin
        got = n;
        break;
      end
    end
  endtask

  task automatic run_vec(input logic [7:0] t,
                         input logic [20:0] sa, input logic [11:0] ba,
                         input logic [20:0] sb,
                         input logic [13:0] sc, input logic [7:0] bc, input logic oc,
                         input logic [20:0] sd, input logic [11:0] bd,
                         input logic nd, input logic od);
    @(negedge clk);
    sv = 1'b1;
    tv = t;
    @(posedge clk);
    #1;
    sv = 1'b0;
    tv = ~t;
    wait_done();
    check_eq("latency", got, 32'd9);
    check_eq("a_seg", ia.seg, sa);
    check_eq("a_bcd", ia.bcd, ba);
    check_eq("a_ovr", {31'd0, ia.over_range}, 32'd0);
    check_eq("b_seg", ib.seg, sb);
    check_eq("b_bcd", ib.bcd, ba);
    check_eq("c_done", {31'd0, ic.done}, 32'd1);
    check_eq("c_seg", ic.seg, sc);
    check_eq("c_bcd", ic.bcd, bc);
    check_eq("c_ovr", {31'd0, ic.over_range}, {31'd0, oc});
    check_eq("d_seg", id.seg, sd);
    check_eq("d_bcd", id.bcd, bd);
    check_eq("d_neg", {31'd0, id.negative}, {31'd0, nd});
    check_eq("d_ovr", {31'd0, id.over_range}, {31'd0, od});
    @(negedge clk);
    check_eq("done_pulse", {31'd0, ia.done}, 32'd0);
    check_eq("ready_back", {31'd0, ia.start_ready}, 32'd1);
  endtask

  initial begin
    // reset with a sample offered: nothing may be accepted
    sv = 1'b1;
    tv = 8'd25;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_seg", ia.seg, 32'h1FFFFF);
    check_eq("rst_bcd", ia.bcd, 32'd0);
    check_eq("rst_done", {31'd0, ia.done}, 32'd0);
    check_eq("rst_busy", {31'd0, ia.busy}, 32'd0);
    check_eq("rst_ready", {31'd0, ia.start_ready}, 32'd1);
    sv  = 1'b0;
    rst = 1'b0;
    got = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (ia.done) got++;
    end
    check_eq("rst_nodone", got, 32'd0);

    run_vec(8'd25,  {SB,S2,S5}, 12'h025, {S0,S2,S5}, {S2,S5}, 8'h25, 1'b0, {SB,S2,S5}, 12'h025, 1'b0, 1'b0);
    run_vec(8'd0,   {SB,SB,S0}, 12'h000, {S0,S0,S0}, {SB,S0}, 8'h00, 1'b0, {SB,SB,S0}, 12'h000, 1'b0, 1'b0);
    run_vec(8'd10,  {SB,S1,S0}, 12'h010, {S0,S1,S0}, {S1,S0}, 8'h10, 1'b0, {SB,S1,S0}, 12'h010, 1'b0, 1'b0);
    run_vec(8'd255, {S2,S5,S5}, 12'h255, {S2,S5,S5}, {SM,SM}, 8'h00, 1'b1, {SB,SM,S1}, 12'h001, 1'b1, 1'b0);
    run_vec(8'd99,  {SB,S9,S9}, 12'h099, {S0,S9,S9}, {S9,S9}, 8'h99, 1'b0, {SB,S9,S9}, 12'h099, 1'b0, 1'b0);
    run_vec(8'hF9,  {S2,S4,S9}, 12'h249, {S2,S4,S9}, {SM,SM}, 8'h00, 1'b1, {SB,SM,S7}, 12'h007, 1'b1, 1'b0);
    run_vec(8'h80,  {S1,S2,S8}, 12'h128, {S1,S2,S8}, {SM,SM}, 8'h00, 1'b1, {SM,SM,SM}, 12'h000, 1'b1, 1'b1);
    run_vec(8'hA5,  {S1,S6,S5}, 12'h165, {S1,S6,S5}, {SM,SM}, 8'h00, 1'b1, {SM,S9,S1}, 12'h091, 1'b1, 1'b0);
    run_vec(8'd100, {S1,S0,S0}, 12'h100, {S1,S0,S0}, {SM,SM}, 8'h00, 1'b1, {S1,S0,S0}, 12'h100, 1'b0, 1'b0);

    // start_valid held with a new sample while busy: taken only once back in IDLE
    @(negedge clk);
    sv = 1'b1;
    tv = 8'd25;
    @(posedge clk);
    #1;
    tv = 8'd99;
    wait_done();
    check_eq("hold_lat1", got, 32'd9);
    check_eq("hold_first", ia.bcd, 32'h025);
    @(posedge clk);
    @(negedge clk);
    check_eq("hold_ready", {31'd0, ia.start_ready}, 32'd1);
    @(posedge clk);
    #1;
    sv = 1'b0;
    wait_done();
    check_eq("hold_lat2", got, 32'd9);
    check_eq("hold_second", ia.bcd, 32'h099);
    @(negedge clk);

    // leave non-reset outputs behind, then abort a conversion with reset
    run_vec(8'd255, {S2,S5,S5}, 12'h255, {S2,S5,S5}, {SM,SM}, 8'h00, 1'b1, {SB,SM,S1}, 12'h001, 1'b1, 1'b0);
    @(negedge clk);
    sv = 1'b1;
    tv = 8'd55;
    @(posedge clk);
    #1;
    sv = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_seg", ia.seg, 32'h1FFFFF);
    check_eq("abort_bcd", ia.bcd, 32'd0);
    check_eq("abort_busy", {31'd0, ia.busy}, 32'd0);
    check_eq("abort_ready", {31'd0, ia.start_ready}, 32'd1);
    check_eq("abort_c_ovr", {31'd0, ic.over_range}, 32'd0);
    check_eq("abort_d_neg", {31'd0, id.negative}, 32'd0);
    got = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (ia.done) got++;
    end
    check_eq("abort_nodone", got, 32'd0);
    run_vec(8'hA5,  {S1,S6,S5}, 12'h165, {S1,S6,S5}, {SM,SM}, 8'h00, 1'b1, {SM,S9,S1}, 12'h091, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
